// File: rtl/key_scanner.sv
// 12-key front end: per-key synchronizers, shared stability debounce, and a
// lowest-index-wins press/release FSM with short/long hold classification.

module key_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end
endmodule

module key_scanner #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 30_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] btn_in,
    output logic [3:0]  key_idx,
    output logic        key_press,
    output logic        key_release,
    output logic        key_long,
    output logic        key_down
);
    localparam int NK = 12;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;

    logic [NK-1:0] s, p, deb, cap;
    logic [DW-1:0] scnt;
    logic [HW-1:0] hcnt;
    state_t        state;
    logic          held, long_hit;

    function automatic logic [3:0] lowest_idx(input logic [NK-1:0] v);
        lowest_idx = '0;
        for (int i = NK - 1; i >= 0; i--)
            if (v[i]) lowest_idx = 4'(i + 1);
    endfunction

    for (genvar g = 0; g < NK; g++) begin : g_sync
        key_sync u_sync (.clk(clk), .rst(rst), .din(btn_in[g]), .dout(s[g]));
    end

    // The edge that clears the counter is the same edge that brings p level
    // with s, so deb loads DEBOUNCE_CYCLES edges after that: D+3 from the raw edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p    <= '0;
            scnt <= '0;
            deb  <= '0;
        end else begin
            p <= s;
            if (s != p) begin
                scnt <= '0;
            end else if (scnt != DW'(DEBOUNCE_CYCLES)) begin
                scnt <= scnt + DW'(1);
                if (scnt == DW'(DEBOUNCE_CYCLES - 1)) deb <= s;
            end
        end
    end

    assign held     = |(deb & cap);
    assign long_hit = (hcnt == HW'(LONG_PRESS_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cap         <= '0;
            hcnt        <= '0;
            key_idx     <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_down    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: begin
                    key_long <= 1'b0;
                    if (deb != '0) begin
                        key_idx   <= lowest_idx(deb);
                        cap       <= deb & (~deb + NK'(1));
                        key_press <= 1'b1;
                        key_down  <= 1'b1;
                        hcnt      <= '0;
                        state     <= PRESSED;
                    end
                end
                PRESSED: begin
                    // the hold still counts on the release edge, so a release
                    // coinciding with saturation reports a long keystroke
                    if (hcnt != HW'(LONG_PRESS_CYCLES)) hcnt <= hcnt + HW'(1);
                    if (long_hit) key_long <= 1'b1;
                    if (!held) begin
                        key_release <= 1'b1;
                        key_down    <= 1'b0;
                        state       <= (deb != '0) ? LOCKOUT : IDLE;
                    end
                end
                LOCKOUT: begin
                    key_long <= 1'b0;
                    if (deb == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
